// File: rtl/bubble_capture_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bubble_capture_pkg : state encoding and default timing constants for the
//                      bubble page capture block.   Revision 1.0
// ---------------------------------------------------------------------------
package bubble_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      CAPTURE = 2'd2
   } cap_state_e;

   localparam int CELL_CYCLES_48M = 480;
   localparam int PAGE_CELLS_STD  = 256;
   localparam int BOOT_CELLS_STD  = 512;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bubble_byte_fifo : synchronous FIFO for captured bytes plus last-of-page flag.
//                    Revision 1.0
// ---------------------------------------------------------------------------
module bubble_byte_fifo
   import bubble_capture_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_AW-1:0]  wr_ptr_q;
   logic [c_AW-1:0]  rd_ptr_q;
   logic [c_AW:0]    count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == c_DEPTH_CNT);
   assign empty_o = (count_q == '0);
   // A push into a full FIFO is refused even when a pop happens in the same cycle
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + c_AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_AW'(1);
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + (c_AW + 1)'(1);
         end else if (w_pop && !w_push) begin
            count_q <= count_q - (c_AW + 1)'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bubble_page_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bubble_page_capture : recovers bubble bit cells after a replicator pulse and
//                       packs DOUT0/DOUT1 pairs into a byte stream.  Revision 1.0
// ---------------------------------------------------------------------------
module bubble_page_capture
   import bubble_capture_pkg::*;
#(
   parameter int CELL_CYCLES = CELL_CYCLES_48M,
   parameter int SAMPLE_OFS  = 240,
   parameter int PAGE_DELAY  = 4,
   parameter int PAGE_CELLS  = PAGE_CELLS_STD,
   parameter int BOOT_CELLS  = BOOT_CELLS_STD,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       MCLK,
   input  logic       MRST,
   input  logic       nBSEN,
   input  logic       nREPEN,
   input  logic       nBOOTEN,
   input  logic       DOUT0,
   input  logic       DOUT1,
   output logic [7:0] BYTE,
   output logic       BYTE_VALID,
   input  logic       BYTE_READY,
   output logic       BYTE_LAST,
   output logic       PAGE_START,
   output logic       PAGE_DONE,
   output logic       PAGE_ABORT,
   output logic       OVERFLOW
);

   localparam int c_CYC_W  = $clog2(CELL_CYCLES);
   localparam int c_CELL_W = $clog2(max_int(BOOT_CELLS, PAGE_CELLS)) + 1;

   localparam logic [c_CYC_W-1:0]  c_CYC_LAST   = c_CYC_W'(CELL_CYCLES - 1);
   localparam logic [c_CYC_W-1:0]  c_CYC_SAMPLE = c_CYC_W'(SAMPLE_OFS);
   localparam logic [c_CELL_W-1:0] c_DLY_LAST   = c_CELL_W'(PAGE_DELAY - 1);
   localparam cap_state_e          c_FIRST_ST   = (PAGE_DELAY == 0) ? CAPTURE : DELAY;

   localparam int c_I_BSEN = 4;
   localparam int c_I_REP  = 3;
   localparam int c_I_BOOT = 2;

   // ---------------- input synchronisers ----------------
   logic [4:0] w_pins;
   logic [4:0] sync1_q;
   logic [4:0] sync2_q;
   logic       rep_dly_q;

   assign w_pins = {nBSEN, nREPEN, nBOOTEN, DOUT1, DOUT0};

   always_ff @(posedge MCLK) begin
      if (MRST) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         rep_dly_q <= 1'b1;
      end else begin
         sync1_q   <= w_pins;
         sync2_q   <= sync1_q;
         rep_dly_q <= sync2_q[c_I_REP];
      end
   end

   logic       w_bsen_off;
   logic       w_rep_fall;
   logic       w_boot_sel;
   logic [1:0] w_pair;

   assign w_bsen_off = sync2_q[c_I_BSEN];
   assign w_rep_fall = ~sync2_q[c_I_REP] & rep_dly_q;
   assign w_boot_sel = ~sync2_q[c_I_BOOT];
   assign w_pair     = ~sync2_q[1:0];

   // ---------------- page FSM ----------------
   cap_state_e          state_q, state_d;
   logic [c_CYC_W-1:0]  cyc_q, cyc_d;
   logic [c_CELL_W-1:0] cell_q, cell_d;
   logic [c_CELL_W-1:0] len_q, len_d;
   logic [5:0]          pack_q, pack_d;
   logic                ovf_q, ovf_d;
   logic                start_q, start_d;
   logic                done_q, done_d;
   logic                abort_q, abort_d;

   logic                w_push;
   logic [8:0]          w_push_data;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_CYC_W-1:0]  w_cyc_next;
   logic                w_last_cell;

   assign w_cyc_next  = (cyc_q == c_CYC_LAST) ? '0 : cyc_q + c_CYC_W'(1);
   assign w_last_cell = (cell_q == len_q - c_CELL_W'(1));

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      cell_d      = cell_q;
      len_d       = len_q;
      pack_d      = pack_q;
      ovf_d       = ovf_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      w_push      = 1'b0;
      w_push_data = {w_last_cell, w_pair, pack_q};

      case (state_q)
         IDLE: begin
            if (!w_bsen_off && w_rep_fall) begin
               state_d = c_FIRST_ST;
               start_d = 1'b1;
               len_d   = w_boot_sel ? c_CELL_W'(BOOT_CELLS) : c_CELL_W'(PAGE_CELLS);
               cyc_d   = '0;
               cell_d  = '0;
               pack_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         DELAY: begin
            if (w_bsen_off) begin
               state_d = IDLE;
               abort_d = 1'b1;
               cyc_d   = '0;
               cell_d  = '0;
               pack_d  = '0;
            end else begin
               cyc_d = w_cyc_next;
               if (cyc_q == c_CYC_LAST) begin
                  if (cell_q == c_DLY_LAST) begin
                     state_d = CAPTURE;
                     cell_d  = '0;
                  end else begin
                     cell_d = cell_q + c_CELL_W'(1);
                  end
               end
            end
         end
         CAPTURE: begin
            if (w_bsen_off) begin
               state_d = IDLE;
               abort_d = 1'b1;
               cyc_d   = '0;
               cell_d  = '0;
               pack_d  = '0;
            end else begin
               cyc_d = w_cyc_next;
               if (cyc_q == c_CYC_SAMPLE) begin
                  // Page lengths are multiples of 4, so the cell index selects the pair slot
                  case (cell_q[1:0])
                     2'd0:    pack_d[1:0] = w_pair;
                     2'd1:    pack_d[3:2] = w_pair;
                     2'd2:    pack_d[5:4] = w_pair;
                     default: begin
                        w_push = 1'b1;
                        pack_d = '0;
                     end
                  endcase
                  cell_d = cell_q + c_CELL_W'(1);
                  if (w_last_cell) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     cyc_d   = '0;
                     cell_d  = '0;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (w_push && w_fifo_full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge MCLK) begin
      if (MRST) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         cell_q  <= '0;
         len_q   <= '0;
         pack_q  <= '0;
         ovf_q   <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cell_q  <= cell_d;
         len_q   <= len_d;
         pack_q  <= pack_d;
         ovf_q   <= ovf_d;
         start_q <= start_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   // ---------------- output FIFO ----------------
   logic [8:0] w_head;

   bubble_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk_i   (MCLK),
      .rst_i   (MRST),
      .push_i  (w_push),
      .data_i  (w_push_data),
      .pop_i   (BYTE_READY),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   assign BYTE       = w_head[7:0];
   assign BYTE_LAST  = w_head[8];
   assign BYTE_VALID = ~w_fifo_empty;
   assign PAGE_START = start_q;
   assign PAGE_DONE  = done_q;
   assign PAGE_ABORT = abort_q;
   assign OVERFLOW   = ovf_q;

endmodule
`default_nettype wire
